// File: rtl/rc_perm_arbiter.sv
// Round-robin arbiter that shares one Reinforced Concrete permutation core among NUM_REQ requesters.
// Optional watchdog on the core job is enabled by defining RC_ARB_TIMEOUT_EN.
module rc_perm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int STATE_SIZE = 3,
  parameter int N_BITS = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*STATE_SIZE*N_BITS-1:0] req_state,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [ID_W-1:0]                      resp_id,
  output logic [STATE_SIZE*N_BITS-1:0]         resp_state,
  output logic                                 resp_err,
  output logic                                 perm_enable,
  output logic [STATE_SIZE*N_BITS-1:0]         perm_in_state,
  input  logic [STATE_SIZE*N_BITS-1:0]         perm_out_state,
  input  logic                                 perm_done,
  output logic                                 busy,
  output logic [15:0]                          job_count
);

  localparam int SW = STATE_SIZE * N_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } arbState_t;

  // 2^N_BITS < 2p, so a single conditional subtraction is a full reduction
  function automatic logic [N_BITS-1:0] reduceLane(input logic [N_BITS-1:0] x);
    logic [N_BITS-1:0] r;
    if (x >= PRIME_MODULUS) begin
      r = x - PRIME_MODULUS;
    end else begin
      r = x;
    end
    return r;
  endfunction

  arbState_t         state_r, stateNext_s;
  logic [ID_W-1:0]   rrPtr_r, rrPtrNext_s;
  logic [ID_W-1:0]   grant_r, grantNext_s;
  logic [NUM_REQ-1:0] reqReady_r, reqReadyNext_s;
  logic [SW-1:0]     capt_r, captNext_s;
  logic              permEn_r, permEnNext_s;
  logic              respValid_r, respValidNext_s;
  logic [ID_W-1:0]   respId_r, respIdNext_s;
  logic [SW-1:0]     respState_r, respStateNext_s;
  logic              busy_r, busyNext_s;
  logic [15:0]       jobCount_r, jobCountNext_s;
  logic              grantValid_s;
  logic [ID_W-1:0]   grantIdx_s;
  logic [SW-1:0]     capt_s;

`ifdef RC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     timer_r, timerNext_s;
  logic              respErr_r, respErrNext_s;
`endif

  // Round-robin search starting at rrPtr_r
  always_comb begin
    logic [ID_W-1:0] cand;
    cand = '0;
    grantValid_s = 1'b0;
    grantIdx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rrPtr_r) + k) % NUM_REQ);
      if (!grantValid_s && req_valid[cand]) begin
        grantValid_s = 1'b1;
        grantIdx_s = cand;
      end else begin
        grantValid_s = grantValid_s;
      end
    end
  end

  // Reduced copy of the granted requester's lanes
  always_comb begin
    capt_s = '0;
    for (int j = 0; j < STATE_SIZE; j++) begin
      capt_s[j*N_BITS +: N_BITS] =
        reduceLane(req_state[(int'(grantIdx_s)*STATE_SIZE + j)*N_BITS +: N_BITS]);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext_s     = state_r;
    rrPtrNext_s     = rrPtr_r;
    grantNext_s     = grant_r;
    reqReadyNext_s  = '0;
    captNext_s      = capt_r;
    permEnNext_s    = permEn_r;
    respValidNext_s = respValid_r;
    respIdNext_s    = respId_r;
    respStateNext_s = respState_r;
    busyNext_s      = busy_r;
    jobCountNext_s  = jobCount_r;
`ifdef RC_ARB_TIMEOUT_EN
    timerNext_s     = timer_r;
    respErrNext_s   = respErr_r;
`endif
    case (state_r)
      IDLE: begin
        if (grantValid_s) begin
          stateNext_s    = RUN;
          grantNext_s    = grantIdx_s;
          reqReadyNext_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grantIdx_s;
          captNext_s     = capt_s;
          busyNext_s     = 1'b1;
`ifdef RC_ARB_TIMEOUT_EN
          timerNext_s    = '0;
`endif
        end else begin
          stateNext_s = IDLE;
        end
      end
      RUN: begin
        // done only counts once enable is visible to the core
        if (permEn_r && perm_done) begin
          stateNext_s     = RESP;
          permEnNext_s    = 1'b0;
          respValidNext_s = 1'b1;
          respIdNext_s    = grant_r;
          respStateNext_s = perm_out_state;
`ifdef RC_ARB_TIMEOUT_EN
          respErrNext_s   = 1'b0;
        end else if (timer_r >= TW'(TIMEOUT_CYCLES - 1)) begin
          stateNext_s     = RESP;
          permEnNext_s    = 1'b0;
          respValidNext_s = 1'b1;
          respIdNext_s    = grant_r;
          respStateNext_s = '0;
          respErrNext_s   = 1'b1;
`endif
        end else begin
          permEnNext_s = 1'b1;
`ifdef RC_ARB_TIMEOUT_EN
          timerNext_s  = timer_r + TW'(1);
`endif
        end
      end
      RESP: begin
        if (resp_ready) begin
          stateNext_s     = IDLE;
          respValidNext_s = 1'b0;
          busyNext_s      = 1'b0;
          jobCountNext_s  = jobCount_r + 16'd1;
          rrPtrNext_s     = (grant_r == ID_W'(NUM_REQ - 1)) ? '0 : grant_r + ID_W'(1);
`ifdef RC_ARB_TIMEOUT_EN
          respErrNext_s   = 1'b0;
`endif
        end else begin
          stateNext_s = RESP;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rrPtr_r     <= '0;
      grant_r     <= '0;
      reqReady_r  <= '0;
      capt_r      <= '0;
      permEn_r    <= 1'b0;
      respValid_r <= 1'b0;
      respId_r    <= '0;
      respState_r <= '0;
      busy_r      <= 1'b0;
      jobCount_r  <= 16'd0;
`ifdef RC_ARB_TIMEOUT_EN
      timer_r     <= '0;
      respErr_r   <= 1'b0;
`endif
    end else begin
      state_r     <= stateNext_s;
      rrPtr_r     <= rrPtrNext_s;
      grant_r     <= grantNext_s;
      reqReady_r  <= reqReadyNext_s;
      capt_r      <= captNext_s;
      permEn_r    <= permEnNext_s;
      respValid_r <= respValidNext_s;
      respId_r    <= respIdNext_s;
      respState_r <= respStateNext_s;
      busy_r      <= busyNext_s;
      jobCount_r  <= jobCountNext_s;
`ifdef RC_ARB_TIMEOUT_EN
      timer_r     <= timerNext_s;
      respErr_r   <= respErrNext_s;
`endif
    end
  end

  assign req_ready     = reqReady_r;
  assign resp_valid    = respValid_r;
  assign resp_id       = respId_r;
  assign resp_state    = respState_r;
  assign perm_enable   = permEn_r;
  assign perm_in_state = capt_r;
  assign busy          = busy_r;
  assign job_count     = jobCount_r;
`ifdef RC_ARB_TIMEOUT_EN
  assign resp_err      = respErr_r;
`else
  assign resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_rc_perm_arbiter.sv
// Bench for rc_perm_arbiter: stub permutation core with a known mapping, vector table and scoreboard.
// With RC_ARB_TIMEOUT_EN defined the DUT is built with a 16-cycle watchdog and a timeout case runs.
module tb_rc_perm_arbiter;
  localparam int NR = 4;
  localparam int NB = 254;
  localparam int SW = 3 * NB;
  localparam logic [NB-1:0] P =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
`ifdef RC_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*SW-1:0] req_state;
  logic resp_valid, resp_ready, resp_err, perm_enable, perm_done, busy;
  logic [1:0] resp_id;
  logic [SW-1:0] resp_state, perm_in_state, perm_out_state;
  logic [15:0] job_count;

  rc_perm_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_state(resp_state), .resp_err(resp_err),
    .perm_enable(perm_enable), .perm_in_state(perm_in_state),
    .perm_out_state(perm_out_state), .perm_done(perm_done), .busy(busy),
    .job_count(job_count));

  always #5 clk = ~clk;

  // Stand-in permutation with an easily modelled mapping
  function automatic logic [SW-1:0] golden(input logic [SW-1:0] s);
    logic [NB-1:0] a, b, c, o0, o1, o2;
    a = s[0 +: NB]; b = s[NB +: NB]; c = s[2*NB +: NB];
    o0 = b + c * 254'd3 + 254'd1;
    o1 = a ^ {c[126:0], c[253:127]};
    o2 = a + b + 254'd99;
    return {o2, o1, o0};
  endfunction

  int coreLat = 1;
  int enCnt = 0;
  logic neverDone = 1'b0, doneForce = 1'b0;
  always @(posedge clk) enCnt <= perm_enable ? enCnt + 1 : 0;
  assign perm_done = doneForce | (perm_enable && !neverDone && enCnt == coreLat);
  assign perm_out_state = golden(perm_in_state);

  typedef struct { logic [1:0] id; logic [SW-1:0] st; logic err; } exp_t;
  typedef struct { int id; int lat; logic [NB-1:0] i0, i1, i2, r0, r1, r2; } vec_t;

  exp_t sbq[$];
  int grantLog[$];
  logic [SW-1:0] reqExp [NR];
  logic [NR-1:0] acceptedMask = '0;
  logic expectErr = 1'b0;
  logic prevEn = 1'b0;
  logic [SW-1:0] prevIn = '0;
  int lowRun = 100, jobsExp = 0, cycle = 0, acceptCyc = 0;
  int passCnt = 0, checkCnt = 0;

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic request(input int i, input logic [SW-1:0] d, input logic [SW-1:0] e);
    req_state[i*SW +: SW] = d;
    reqExp[i] = e;
    req_valid[i] = 1'b1;
  endtask

  // One cycle: observe handshakes at negedge, release accepted requesters after the edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (req_ready != 4'b0000) chk("req_ready_onehot", SW'($countones(req_ready)), SW'(1));
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id = 2'(i);
        e.st = expectErr ? '0 : reqExp[i];
        e.err = expectErr;
        sbq.push_back(e);
        grantLog.push_back(i);
        acceptedMask[i] = 1'b1;
        acceptCyc = cycle;
      end
    end
    if (resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        checkCnt++;
        $display("FAIL stale_resp: got response id %0d expected none", resp_id);
      end else begin
        e = sbq.pop_front();
        chk("resp_id", SW'(resp_id), SW'(e.id));
        chk("resp_state", resp_state, e.st);
        chk("resp_err", SW'(resp_err), SW'(e.err));
      end
      jobsExp++;
    end
    if (perm_enable && prevEn) chk("perm_in_stable", perm_in_state, prevIn);
    if (perm_enable && !prevEn) chk("perm_gap_ge2", SW'(lowRun >= 2), SW'(1));
    lowRun = perm_enable ? 0 : lowRun + 1;
    prevEn = perm_enable;
    prevIn = perm_in_state;
    @(posedge clk); #1;
    req_valid = req_valid & ~acceptedMask;
    acceptedMask = '0;
    cycle++;
  endtask

  task automatic waitIdle(input int maxc);
    int n = 0;
    do begin step(); n++; end
    while ((busy || resp_valid || req_valid != '0 || sbq.size() != 0) && n < maxc);
    if (n >= maxc) begin
      checkCnt++;
      $display("FAIL wait_idle: got still busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    req_valid = '0;
    step(); step();
    reset = 1'b0;
    sbq.delete();
    grantLog.delete();
    jobsExp = 0;
  endtask

  function automatic logic [SW-1:0] mkData(input int s);
    return {NB'(s * 3 + 2), NB'(s + 1), NB'(s ^ 32'h55)};
  endfunction

  vec_t tbl [6];
  logic [NB-1:0] ones;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int serial;
    logic [SW-1:0] d, held;
    reset = 1'b1; req_valid = '0; req_state = '0; resp_ready = 1'b0;
    ones = '1;
    doReset();
    chk("rst_req_ready", SW'(req_ready), SW'(0));
    chk("rst_resp_valid", SW'(resp_valid), SW'(0));
    chk("rst_resp_state", resp_state, SW'(0));
    chk("rst_perm_enable", SW'(perm_enable), SW'(0));
    chk("rst_perm_in", perm_in_state, SW'(0));
    chk("rst_busy_jobs", SW'({busy, resp_err, job_count}), SW'(0));

    tbl[0] = '{0, 2, 254'd7, 254'd5, 254'd0, 254'd7, 254'd5, 254'd0};
    tbl[1] = '{1, 0, P + 254'd7, 254'd5, 254'd0, 254'd7, 254'd5, 254'd0};
    tbl[2] = '{2, 1, P, P - 254'd1, 254'd1, 254'd0, P - 254'd1, 254'd1};
    tbl[3] = '{3, 3, ones, 254'd0, P + 254'd1, ones - P, 254'd0, 254'd1};
    tbl[4] = '{0, 5, 254'h1234_5678_9abc, 254'hdead_beef, 254'h42, 254'h1234_5678_9abc, 254'hdead_beef, 254'h42};
    tbl[5] = '{2, 0, 254'd1, 254'd2, 254'd3, 254'd1, 254'd2, 254'd3};
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      coreLat = tbl[k].lat;
      grantLog.delete();
      request(tbl[k].id, {tbl[k].i2, tbl[k].i1, tbl[k].i0}, golden({tbl[k].r2, tbl[k].r1, tbl[k].r0}));
      waitIdle(60);
      chk("vec_grant", SW'(grantLog.size() > 0 ? grantLog[0] : -1), SW'(tbl[k].id));
      chk("vec_job_count", SW'(job_count), SW'(jobsExp));
    end
    chk("job_count_six", SW'(job_count), SW'(6));

    // All requesters asserting continuously
    doReset();
    resp_ready = 1'b1; coreLat = 1; serial = 0;
    for (int c = 0; c < 300 && grantLog.size() < 5; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          d = mkData(serial); serial++;
          request(i, d, golden(d));
        end
      end
      step();
    end
    waitIdle(200);
    for (int g = 0; g < 5; g++)
      chk("fair_order", SW'(grantLog.size() > g ? grantLog[g] : -1), SW'(g % NR));

    // Back-pressure on the response port, with a waiting requester and spurious done
    resp_ready = 1'b0; coreLat = 2;
    d = mkData(500); held = golden(d);
    request(1, d, held);
    for (int c = 0; c < 30 && !resp_valid; c++) step();
    d = mkData(600);
    request(3, d, golden(d));
    for (int c = 0; c < 20; c++) begin
      doneForce = (c == 5);
      step();
      chk("bp_valid", SW'(resp_valid), SW'(1));
      chk("bp_id", SW'(resp_id), SW'(1));
      chk("bp_state", resp_state, held);
      chk("bp_no_ready", SW'(req_ready), SW'(0));
      chk("bp_perm_en", SW'(perm_enable), SW'(0));
    end
    doneForce = 1'b0; resp_ready = 1'b1;
    waitIdle(80);
    chk("bp_jobs", SW'(job_count), SW'(jobsExp));

    // Spurious done while idle
    doneForce = 1'b1;
    step(); step(); step();
    doneForce = 1'b0;
    chk("idle_done_ignored", SW'({busy, resp_valid, perm_enable}), SW'(0));

    // Reset in the middle of a job; rr pointer returns to 0
    d = mkData(700); request(2, d, golden(d));
    waitIdle(40);
    neverDone = 1'b1;
    d = mkData(800); request(0, d, golden(d));
    for (int c = 0; c < 10 && !perm_enable; c++) step();
    step();
    doReset();
    neverDone = 1'b0;
    chk("rst_mid_jobs", SW'(job_count), SW'(0));
    chk("rst_mid_idle", SW'({busy, resp_valid, perm_enable}), SW'(0));
    d = mkData(900); request(3, d, golden(d));
    d = mkData(901); request(2, d, golden(d));
    waitIdle(80);
    chk("rst_rr_first", SW'(grantLog.size() > 0 ? grantLog[0] : -1), SW'(2));
    chk("rst_rr_second", SW'(grantLog.size() > 1 ? grantLog[1] : -1), SW'(3));
    chk("rst_jobs_after", SW'(job_count), SW'(2));

`ifdef RC_ARB_TIMEOUT_EN
    neverDone = 1'b1; expectErr = 1'b1; resp_ready = 1'b0;
    d = mkData(1000); request(1, d, golden(d));
    for (int c = 0; c < 40 && !resp_valid; c++) step();
    chk("to_latency", SW'((cycle - acceptCyc) <= 18), SW'(1));
    chk("to_err", SW'(resp_err), SW'(1));
    resp_ready = 1'b1;
    waitIdle(20);
    neverDone = 1'b0; expectErr = 1'b0;
    chk("to_jobs", SW'(job_count), SW'(3));
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule

// File: doc/rc_perm_arbiter.md
Name: rc_perm_arbiter

Overview:
- Shares one Reinforced Concrete permutation core (BN254 scalar field, 3-lane state) among NUM_REQ independent requesters.
- Arbitrates requests round-robin, reduces and latches the input state, and sequences the core's enable/done protocol.
- Returns each result, tagged with the requester ID, over a valid/ready response port.
- Sits between the sponge/hash front-ends and the single permutation instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STATE_SIZE, 3, field elements per state.
- N_BITS, 254, bits per field element.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p.
- ID_W, $clog2(NUM_REQ), width of resp_id.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept; a transfer happens when req_valid[i] and req_ready[i] are both high.
- req_state  in  NUM_REQ*STATE_SIZE*N_BITS  requester i, lane j at bits [(i*STATE_SIZE+j)*N_BITS +: N_BITS].
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumed.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_state  out  STATE_SIZE*N_BITS  permuted state, lane j at [j*N_BITS +: N_BITS].
- resp_err  out  1  result invalid (timeout).
- perm_enable  out  1  core start; held high for the whole job.
- perm_in_state  out  STATE_SIZE*N_BITS  core input, held stable while perm_enable is high.
- perm_out_state  in  STATE_SIZE*N_BITS  core output.
- perm_done  in  1  core completion.
- busy  out  1  high in any state other than IDLE.
- job_count  out  16  number of completed jobs, wraps at 0xFFFF to 0.

Behaviour:
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - All outputs 0, including req_ready, resp_valid, resp_state, resp_err, perm_enable, perm_in_state, busy and job_count.
- IDLE:
  - Grant g is the first index with req_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g] is a registered one-cycle pulse driven in the cycle after grant.
  - Each lane x is captured as x>=p ? x-p : x. One subtraction fully reduces any 254-bit value because 2^254 < 2p.
  - Next state: RUN. At most one req_ready bit is ever high.
- RUN:
  - perm_enable is driven 1 starting the cycle after acceptance; perm_in_state is the captured register.
  - When perm_done is sampled high: register perm_out_state into resp_state, set resp_id=g and resp_valid=1, drop perm_enable the next cycle, go to RESP.
- RESP:
  - resp_valid is held and resp_state/resp_id are stable until resp_ready is sampled high.
  - On that cycle: job_count += 1, rr_ptr = (g+1) mod NUM_REQ, go to IDLE.
  - perm_enable is guaranteed low for at least 2 cycles between jobs.
- Request rules:
  - A requester drops req_valid only after its handshake.
  - Requests arriving while busy wait; they are never lost.
- Fairness: with all requesters asserting continuously, grants cycle 0,1,2,...,NUM_REQ-1,0.
- Edge cases:
  - perm_done asserted in IDLE or RESP is ignored.
  - perm_done in the same cycle as perm_enable first rises is accepted.
  - Reset in any state returns everything to reset values on the next edge. The in-flight job is discarded with no response and no req_ready.

Optional Feature:
- Macro: RC_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to RUN.
  - If it reaches TIMEOUT_CYCLES without perm_done: drop perm_enable, go to RESP with resp_err=1 and resp_state=0.
  - job_count still increments on the response handshake.
- Undefined: no counter; resp_err is tied to 0; RUN waits indefinitely.

Test Plan:
- Reset, then req_valid[0]=1 with state [7,5,0] and the real core attached → one req_ready[0] pulse; later resp_id=0, resp_err=0, lane0 = 12360106593270449844061412657301362366573579256583003766552363058581964117186; job_count=1.
- req_valid=4'b1111 held, resp_ready=1 → grant order 0,1,2,3,0; each output matches the golden permutation of that requester's input.
- Input lane0 = p+7 (254-bit), lanes [_,5,0] → result identical to input [7,5,0].
- resp_ready held 0 for 20 cycles after resp_valid → resp_state/resp_id stable, no new req_ready, perm_enable=0; release → IDLE.
- Assert reset mid-RUN, then issue a new request from requester 2 → no stale response; rr_ptr=0; the new job completes correctly.
- With RC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a stub core that never asserts done → resp_err=1 and resp_state=0 within 18 cycles of acceptance.
